// File: rtl/fix_timestamp_serializer.sv
// Snapshots the 17 BCD digits of the GMT millisecond timestamp on request.
// The snapshot is streamed as ASCII bytes over a valid/ready byte interface for the FIX SendingTime field.
module fix_timestamp_serializer #(
  parameter int INCLUDE_MS = 1,
  parameter int PREFIX_EN  = 0,
  parameter int SUFFIX_SOH = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [67:0] ts_digits,
  input  logic        start,
  output logic        busy,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        bcd_err
);

  localparam int         FRAME_LEN  = 3 * PREFIX_EN + ((INCLUDE_MS != 0) ? 21 : 17) + SUFFIX_SOH;
  localparam logic [4:0] LAST_IDX   = 5'(FRAME_LEN - 1);
  localparam logic [4:0] PREFIX_LEN = 5'(3 * PREFIX_EN);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_r;
  logic [67:0] snap_r;
  logic [4:0]  index_r;
  logic        accept_s;
  logic [4:0]  next_idx_s;

  function automatic logic [7:0] digit_char(input logic [3:0] nib);
    if (nib > 4'd9) return 8'h3F;
    else return 8'h30 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] nib_char(input logic [67:0] d, input int k);
    return digit_char(d[4*k +: 4]);
  endfunction

  function automatic logic any_bad_digit(input logic [67:0] d);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 17; k++) begin
      if (d[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Byte at frame position idx: optional "52=", timestamp characters, optional SOH
  function automatic logic [7:0] frame_char(input logic [4:0] idx, input logic [67:0] d);
    logic [4:0] pos;
    logic [7:0] ch;
    pos = idx - PREFIX_LEN;
    if ((PREFIX_EN != 0) && (idx < 5'd3)) begin
      case (idx)
        5'd0:    ch = 8'h35;
        5'd1:    ch = 8'h32;
        default: ch = 8'h3D;
      endcase
    end else if ((SUFFIX_SOH != 0) && (idx == LAST_IDX)) begin
      ch = 8'h01;
    end else begin
      case (pos)
        5'd0:    ch = nib_char(d, 16);
        5'd1:    ch = nib_char(d, 15);
        5'd2:    ch = nib_char(d, 14);
        5'd3:    ch = nib_char(d, 13);
        5'd4:    ch = nib_char(d, 12);
        5'd5:    ch = nib_char(d, 11);
        5'd6:    ch = nib_char(d, 10);
        5'd7:    ch = nib_char(d, 9);
        5'd8:    ch = 8'h2D;
        5'd9:    ch = nib_char(d, 8);
        5'd10:   ch = nib_char(d, 7);
        5'd11:   ch = 8'h3A;
        5'd12:   ch = nib_char(d, 6);
        5'd13:   ch = nib_char(d, 5);
        5'd14:   ch = 8'h3A;
        5'd15:   ch = nib_char(d, 4);
        5'd16:   ch = nib_char(d, 3);
        5'd17:   ch = 8'h2E;
        5'd18:   ch = nib_char(d, 2);
        5'd19:   ch = nib_char(d, 1);
        5'd20:   ch = nib_char(d, 0);
        default: ch = 8'h00;
      endcase
    end
    return ch;
  endfunction

  assign accept_s   = out_valid && out_ready;
  assign next_idx_s = index_r + 5'd1;

  // Frame FSM; the next byte is precomputed on acceptance so outputs stay registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      snap_r    <= 68'h0;
      index_r   <= 5'd0;
      busy      <= 1'b0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      bcd_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= SEND;
            snap_r    <= ts_digits;
            index_r   <= 5'd0;
            bcd_err   <= any_bad_digit(ts_digits);
            out_data  <= frame_char(5'd0, ts_digits);
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            busy      <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          if (accept_s && out_last) begin
            state_r   <= IDLE;
            index_r   <= 5'd0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
          end else if (accept_s) begin
            index_r  <= next_idx_s;
            out_data <= frame_char(next_idx_s, snap_r);
            out_last <= (next_idx_s == LAST_IDX);
          end else begin
            state_r <= SEND;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_timestamp_serializer.sv
// Scoreboard bench: stimulus pushes hand-written expected frames, monitors pop on each accepted byte.
// DUT a uses default parameters; DUT b has the "52=" prefix and SOH suffix, no milliseconds.
module tb_fix_timestamp_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [67:0] a_digits, b_digits;
  logic        a_start, b_start, a_ready, b_ready;
  logic        a_busy, b_busy, a_valid, b_valid, a_last, b_last, a_err, b_err;
  logic [7:0]  a_data, b_data;

  int tests = 0;
  int fails = 0;
  int a_acc = 0;
  logic [8:0] qa[$];
  logic [8:0] qb[$];

  always #5 clk = ~clk;

  fix_timestamp_serializer dut_a (
    .clk(clk), .rst(rst), .ts_digits(a_digits), .start(a_start), .busy(a_busy),
    .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready), .out_last(a_last), .bcd_err(a_err)
  );

  fix_timestamp_serializer #(.INCLUDE_MS(0), .PREFIX_EN(1), .SUFFIX_SOH(1)) dut_b (
    .clk(clk), .rst(rst), .ts_digits(b_digits), .start(b_start), .busy(b_busy),
    .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready), .out_last(b_last), .bcd_err(b_err)
  );

  function automatic logic [67:0] mk(input string s);
    logic [67:0] d;
    byte c;
    d = 68'h0;
    for (int i = 0; i < 17; i++) begin
      c = s[i];
      if (c >= "A") d[4*(16-i) +: 4] = 4'(c - "A" + 10);
      else d[4*(16-i) +: 4] = 4'(c - "0");
    end
    return d;
  endfunction

  task automatic push_exp(input int which, input string s, input bit soh);
    logic [8:0] e;
    for (int i = 0; i < s.len(); i++) begin
      e = {((i == s.len() - 1) && !soh), 8'(s[i])};
      if (which == 0) qa.push_back(e); else qb.push_back(e);
    end
    if (soh) begin
      if (which == 0) qa.push_back({1'b1, 8'h01}); else qb.push_back({1'b1, 8'h01});
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic go(input int which);
    @(posedge clk); #1;
    if (which == 0) a_start = 1'b1; else b_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic wait_done(input int which);
    for (int n = 0; n < 200; n++) begin
      if (((which == 0) ? a_busy : b_busy) == 1'b0) break;
      @(posedge clk); #1;
    end
    check("frame_done_busy", {31'd0, ((which == 0) ? a_busy : b_busy)}, 32'd0);
    check("queue_drained", (which == 0) ? qa.size() : qb.size(), 32'd0);
  endtask

  // Monitor for dut_a: scoreboard compare on acceptance, stability check while stalled
  logic [8:0] a_hold;
  bit         a_hold_v = 1'b0;
  always @(negedge clk) begin
    if (!rst && a_valid) begin
      if (a_hold_v) check("a_hold_stable", {23'd0, a_last, a_data}, {23'd0, a_hold});
      if (a_ready) begin
        if (qa.size() == 0) check("a_unexpected_byte", {23'd0, a_last, a_data}, 32'h1FF);
        else check("a_byte", {23'd0, a_last, a_data}, {23'd0, qa.pop_front()});
        a_acc++;
        a_hold_v = 1'b0;
      end else begin
        a_hold   = {a_last, a_data};
        a_hold_v = 1'b1;
      end
    end else begin
      a_hold_v = 1'b0;
    end
  end

  // Monitor for dut_b
  always @(negedge clk) begin
    if (!rst && b_valid && b_ready) begin
      if (qb.size() == 0) check("b_unexpected_byte", {23'd0, b_last, b_data}, 32'h1FF);
      else check("b_byte", {23'd0, b_last, b_data}, {23'd0, qb.pop_front()});
    end
  end

  initial begin
    rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    a_digits = mk("20200229235959999");
    b_digits = mk("20181231235959123");
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_valid", {31'd0, a_valid}, 32'd0);
    check("rst_last", {31'd0, a_last}, 32'd0);
    check("rst_data", {24'd0, a_data}, 32'h00);
    check("rst_err", {31'd0, a_err}, 32'd0);
    check("rst_b_valid", {31'd0, b_valid}, 32'd0);
    rst = 1'b0;

    // 1: plain frame at full rate
    push_exp(0, "20200229-23:59:59.999", 1'b0);
    go(0);
    check("t1_first_valid", {31'd0, a_valid}, 32'd1);
    check("t1_busy", {31'd0, a_busy}, 32'd1);
    wait_done(0);
    check("t1_err", {31'd0, a_err}, 32'd0);

    // 2: stalled frame with a digit change mid-frame
    push_exp(0, "20200229-23:59:59.999", 1'b0);
    go(0);
    for (int c = 0; c < 200 && a_busy; c++) begin
      a_ready = ((c % 3) == 0);
      if (c == 10) a_digits = mk("20200301000000000");
      @(posedge clk); #1;
    end
    a_ready = 1'b1;
    wait_done(0);

    // 3: prefix + SOH, no milliseconds
    push_exp(1, "52=20181231-23:59:59", 1'b1);
    go(1);
    wait_done(1);

    // 4: bad hour digit, then recovery
    a_digits = mk("202002292C5959999");
    push_exp(0, "20200229-2?:59:59.999", 1'b0);
    go(0);
    check("t4_err_set", {31'd0, a_err}, 32'd1);
    wait_done(0);
    check("t4_err_sticky", {31'd0, a_err}, 32'd1);
    a_digits = mk("20200229235959999");
    push_exp(0, "20200229-23:59:59.999", 1'b0);
    go(0);
    check("t4_err_clear", {31'd0, a_err}, 32'd0);
    wait_done(0);

    // 5: starts while busy and on final acceptance are ignored
    push_exp(0, "20200229-23:59:59.999", 1'b0);
    go(0);
    repeat (4) @(posedge clk);
    #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int n = 0; n < 100 && !(a_valid && a_last); n++) begin
      @(posedge clk); #1;
    end
    check("t5_saw_last", {31'd0, a_last}, 32'd1);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("t5_idle_busy", {31'd0, a_busy}, 32'd0);
    check("t5_idle_valid", {31'd0, a_valid}, 32'd0);
    push_exp(0, "20200229-23:59:59.999", 1'b0);
    go(0);
    wait_done(0);

    // 6: reset mid-frame while stalled
    push_exp(0, "20200229-23:59:59.999", 1'b0);
    a_acc = 0;
    go(0);
    for (int n = 0; n < 100 && a_acc < 9; n++) begin
      @(posedge clk); #1;
    end
    a_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    qa.delete();
    check("t6_valid", {31'd0, a_valid}, 32'd0);
    check("t6_busy", {31'd0, a_busy}, 32'd0);
    check("t6_data", {24'd0, a_data}, 32'h00);
    check("t6_last", {31'd0, a_last}, 32'd0);
    rst = 1'b0;
    a_ready = 1'b1;
    push_exp(0, "20200229-23:59:59.999", 1'b0);
    go(0);
    wait_done(0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
